gpr_scoreboard: RTL and testbench
=================================

Name: gpr_scoreboard

Overview:
- Holds the per-byte-lane "pending write" state for the 8 x86 GPRs.
- Drives the 24-bit GPR_SCOREBOARD bus that the register-read stage's dependency checkers consume.
- Lanes are marked busy when an instruction that writes a GPR leaves the read stage, and released when its writeback retires.
- Supports two producer slots per cycle (e.g. MUL EDX:EAX, XCHG) and a full pipeline flush.

Parameters:
- CNT_W, 2, width of the per-lane pending counter. Used only when GPR_SB_COUNT_EN is defined.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous reset, active-low
- FLUSH  in  1  synchronous clear of all lanes (pipeline flush)
- SET0_V  in  1  issue slot 0 valid (instruction advancing out of read stage)
- SET0_REG  in  3  destination GPR id, slot 0
- SET0_SIZE  in  2  00=8b, 01=16b, 10=32b, 11=64b (no GPR)
- SET1_V, SET1_REG, SET1_SIZE  in  1/3/2  issue slot 1, same encoding as slot 0
- CLR0_V, CLR0_REG, CLR0_SIZE  in  1/3/2  writeback release slot 0
- CLR1_V, CLR1_REG, CLR1_SIZE  in  1/3/2  writeback release slot 1
- GPR_SCOREBOARD  out  24  {sb7[2:0],...,sb0[2:0]}; per register, bit0=byte[7:0], bit1=byte[15:8], bit2=bits[31:16]
- SB_FULL  out  1  any lane counter saturated (0 when the counting feature is off)

Behaviour:
- Lane decode, identical for set and clear slots:
  - SIZE=00, REG[2]=0: reg REG[1:0], lane0.
  - SIZE=00, REG[2]=1: reg REG[1:0], lane1 (AH/CH/DH/BH).
  - SIZE=01: reg REG, lanes 0 and 1.
  - SIZE=10: reg REG, lanes 0, 1 and 2.
  - SIZE=11: no lanes.
- All 24 lane bits are registered. GPR_SCOREBOARD is driven directly from the flops, with no combinational path from the inputs.
- Update precedence per lane each rising CLK edge:
  - FLUSH: all lanes go to 0. Set and clear inputs are ignored that cycle.
  - Otherwise, set requested (either slot): next=1. A new producer wins over the old one's release.
  - Otherwise, clear requested (either slot): next=0.
  - Otherwise: hold.
- Both set slots may hit the same lane: next=1, no error. Both clear slots may hit the same lane: next=0.
- Clearing an already-clear lane is a no-op.
- Update latency is 1 cycle: a set at edge N is visible on GPR_SCOREBOARD after edge N. A clear at edge N removes the stall on cycle N+1.
- Reset (RST low, asynchronous): all lanes 0, SB_FULL 0. RST asserted mid-operation drops every pending lane immediately, without waiting for a clock edge.
- SB_FULL is 0 when GPR_SB_COUNT_EN is undefined.

Optional Feature:
- GPR_SB_COUNT_EN defined:
  - Each lane holds a CNT_W-bit pending counter instead of a single bit. The output bit is (cnt != 0).
  - Per lane: next = cnt + (#set hits) - (#clear hits), with hits counted over both slots (0..2 each).
  - Simultaneous set and clear on the same lane net out: the lane stays busy if the result is > 0.
  - Decrement saturates at 0. Increment saturates at 2^CNT_W-1.
  - SB_FULL = 1 when any counter equals 2^CNT_W-1. The read stage must stall issue while SB_FULL=1.
  - FLUSH and reset zero all counters.
- GPR_SB_COUNT_EN undefined: single-bit lanes with set-wins precedence as described in Behaviour. SB_FULL is tied to 0.

Test Plan:
- Reset then idle:
  - Release RST, leave all V inputs low for 5 cycles -> GPR_SCOREBOARD=24'h000000 throughout; SB_FULL=0.
- 8-bit high-byte decode:
  - SET0 REG=3'b100 SIZE=00 -> next cycle GPR_SCOREBOARD=24'h000002 (AH = EAX lane1).
  - Then CLR0 with the same REG/SIZE -> 24'h000000.
- Dual issue:
  - SET0 REG=0 SIZE=10 and SET1 REG=2 SIZE=10 in one cycle -> 24'h0001C7.
  - Then CLR1 REG=2 SIZE=01 -> 24'h000107.
- Simultaneous set and clear on EBX (REG=3, SIZE=10), lanes preloaded set:
  - Count mode off -> 24'h000E00 (stays set).
  - Count mode on, counters at 1 -> count stays 1, bits stay set.
- Flush and async reset:
  - FLUSH with SET0 REG=1 SIZE=10 in the same cycle -> 24'h000000.
  - Separately, assert RST between clock edges -> output 0 before the next edge.
- Count mode saturation (CNT_W=2):
  - Three SET0 of REG=5 SIZE=00 -> SB_FULL=1 and lane bit set.
  - A fourth SET0 keeps the count at 3.
  - Three CLR0 -> lane 0; a further CLR0 keeps the count at 0.

Source files
------------

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: per-byte-lane pending-write scoreboard for the 8 GPRs (24-bit bus).
// Define GPR_SB_COUNT_EN for saturating per-lane pending counters and SB_FULL.
module gpr_scoreboard
`ifdef GPR_SB_COUNT_EN
  #(parameter int CNT_W = 2)
`endif
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_set0_v,
  input  logic [2:0]  i_set0_reg,
  input  logic [1:0]  i_set0_size,
  input  logic        i_set1_v,
  input  logic [2:0]  i_set1_reg,
  input  logic [1:0]  i_set1_size,
  input  logic        i_clr0_v,
  input  logic [2:0]  i_clr0_reg,
  input  logic [1:0]  i_clr0_size,
  input  logic        i_clr1_v,
  input  logic [2:0]  i_clr1_reg,
  input  logic [1:0]  i_clr1_size,
  output logic [23:0] o_gpr_scoreboard,
  output logic        o_sb_full
);
  // 8-bit ids 4..7 name the high byte (AH..BH) of registers 0..3
  function automatic logic [23:0] f_lanes(input logic v, input logic [2:0] r, input logic [1:0] s);
    logic [2:0] l;
    logic [2:0] id;
    l  = (s == 2'b00) ? (r[2] ? 3'b010 : 3'b001) : (s == 2'b01) ? 3'b011 : (s == 2'b10) ? 3'b111 : 3'b000;
    id = (s == 2'b00) ? {1'b0, r[1:0]} : r;
    return v ? ({21'd0, l} << (5'(id) * 5'd3)) : 24'd0;
  endfunction
  logic [23:0] w_set0, w_set1, w_clr0, w_clr1;
  assign w_set0 = f_lanes(i_set0_v, i_set0_reg, i_set0_size);
  assign w_set1 = f_lanes(i_set1_v, i_set1_reg, i_set1_size);
  assign w_clr0 = f_lanes(i_clr0_v, i_clr0_reg, i_clr0_size);
  assign w_clr1 = f_lanes(i_clr1_v, i_clr1_reg, i_clr1_size);
`ifdef GPR_SB_COUNT_EN
  localparam logic [CNT_W+1:0] MAX = {2'b00, {CNT_W{1'b1}}};
  logic [CNT_W-1:0] r_cnt [24];
  logic [23:0]      w_full;
  for (genvar i = 0; i < 24; i++) begin : g_lane
    logic [1:0]       w_ns, w_nc;
    logic [CNT_W+1:0] w_up, w_dn;
    assign w_ns = {1'b0, w_set0[i]} + {1'b0, w_set1[i]};
    assign w_nc = {1'b0, w_clr0[i]} + {1'b0, w_clr1[i]};
    // net the hits first, then clamp to [0, MAX]
    assign w_up = {2'b00, r_cnt[i]} + {{CNT_W{1'b0}}, w_ns};
    assign w_dn = (w_up < {{CNT_W{1'b0}}, w_nc}) ? '0 : w_up - {{CNT_W{1'b0}}, w_nc};
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_cnt[i] <= '0;
      else r_cnt[i] <= i_flush ? '0 : (w_dn > MAX) ? MAX[CNT_W-1:0] : w_dn[CNT_W-1:0];
    assign o_gpr_scoreboard[i] = |r_cnt[i];
    assign w_full[i] = &r_cnt[i];
  end
  assign o_sb_full = |w_full;
`else
  logic [23:0] r_sb;
  // a new producer's set beats an older producer's release on the same lane
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_sb <= '0;
    else r_sb <= i_flush ? '0 : (r_sb & ~(w_clr0 | w_clr1)) | w_set0 | w_set1;
  assign o_gpr_scoreboard = r_sb;
  assign o_sb_full = 1'b0;
`endif
endmodule

// File: tb/tb_gpr_scoreboard.sv
// tb_gpr_scoreboard: directed self-checking bench for gpr_scoreboard (both build modes).
module tb_gpr_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        s0_v = 1'b0, s1_v = 1'b0, c0_v = 1'b0, c1_v = 1'b0;
  logic [2:0]  s0_r = '0, s1_r = '0, c0_r = '0, c1_r = '0;
  logic [1:0]  s0_s = '0, s1_s = '0, c0_s = '0, c1_s = '0;
  logic [23:0] sb;
  logic        full;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  gpr_scoreboard dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_set0_v(s0_v), .i_set0_reg(s0_r), .i_set0_size(s0_s),
    .i_set1_v(s1_v), .i_set1_reg(s1_r), .i_set1_size(s1_s),
    .i_clr0_v(c0_v), .i_clr0_reg(c0_r), .i_clr0_size(c0_s),
    .i_clr1_v(c1_v), .i_clr1_reg(c1_r), .i_clr1_size(c1_s),
    .o_gpr_scoreboard(sb), .o_sb_full(full)
  );

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic [2:0] r, input logic [1:0] s); s0_v = 1; s0_r = r; s0_s = s; endtask
  task automatic set1(input logic [2:0] r, input logic [1:0] s); s1_v = 1; s1_r = r; s1_s = s; endtask
  task automatic clr0(input logic [2:0] r, input logic [1:0] s); c0_v = 1; c0_r = r; c0_s = s; endtask
  task automatic clr1(input logic [2:0] r, input logic [1:0] s); c1_v = 1; c1_r = r; c1_s = s; endtask

  // one clock edge, then sample 1 time unit later and drop all requests
  task automatic tick;
    @(posedge clk);
    #1;
    s0_v = 0; s1_v = 0; c0_v = 0; c1_v = 0; flush = 0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("reset_sb", sb, 24'h0);
    chk("reset_full", {23'd0, full}, 24'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("idle%0d", i), sb, 24'h0);
    end
    chk("idle_full", {23'd0, full}, 24'h0);

    set0(3'b100, 2'b00);
    #1 chk("ah_no_comb_path", sb, 24'h0);
    tick;
    chk("ah_set", sb, 24'h000002);
    clr0(3'b100, 2'b00);
    tick;
    chk("ah_clr", sb, 24'h0);

    set0(3'd0, 2'b10);
    set1(3'd2, 2'b10);
    tick;
    chk("dual_set", sb, 24'h0001C7);
    clr1(3'd2, 2'b01);
    tick;
    chk("clr16_edx", sb, 24'h000107);

    set0(3'd7, 2'b11);
    tick;
    chk("size64_noop", sb, 24'h000107);
    set0(3'd5, 2'b00);
    set1(3'd6, 2'b01);
    tick;
    chk("ch_and_si16", sb, 24'h0C0117);
    clr0(3'd0, 2'b10);
    clr1(3'd0, 2'b00);
    tick;
    chk("dual_clr_same", sb, 24'h0C0110);
    clr0(3'd0, 2'b10);
    tick;
    chk("clr_already_clear", sb, 24'h0C0110);

    flush = 1'b1;
    set0(3'd1, 2'b10);
    tick;
    chk("flush_beats_set", sb, 24'h0);

    set0(3'd3, 2'b10);
    tick;
    chk("ebx_preload", sb, 24'h000E00);
    set0(3'd3, 2'b10);
    clr0(3'd3, 2'b10);
    tick;
    chk("ebx_set_and_clr", sb, 24'h000E00);
    clr0(3'd3, 2'b10);
    tick;
    chk("ebx_release", sb, 24'h0);
    set1(3'd3, 2'b00);
    clr0(3'd3, 2'b10);
    tick;
`ifdef GPR_SB_COUNT_EN
    chk("bl_set_vs_ebx_clr", sb, 24'h0);
`else
    chk("bl_set_vs_ebx_clr", sb, 24'h000200);
`endif
    flush = 1'b1;
    tick;

    set0(3'd7, 2'b10);
    tick;
    chk("edi_set", sb, 24'hE00000);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", sb, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("after_reset", sb, 24'h0);

`ifdef GPR_SB_COUNT_EN
    set0(3'd5, 2'b00);
    tick;
    chk("cnt1_sb", sb, 24'h000010);
    chk("cnt1_full", {23'd0, full}, 24'h0);
    set0(3'd5, 2'b00);
    tick;
    set0(3'd5, 2'b00);
    tick;
    chk("cnt3_full", {23'd0, full}, 24'h1);
    chk("cnt3_sb", sb, 24'h000010);
    set0(3'd5, 2'b00);
    tick;
    chk("cnt_sat_full", {23'd0, full}, 24'h1);
    clr0(3'd5, 2'b00);
    tick;
    chk("cnt2_full", {23'd0, full}, 24'h0);
    clr0(3'd5, 2'b00);
    tick;
    chk("cnt1_after_clr", sb, 24'h000010);
    clr0(3'd5, 2'b00);
    tick;
    chk("cnt0_sb", sb, 24'h0);
    clr0(3'd5, 2'b00);
    tick;
    chk("cnt_floor", sb, 24'h0);
    set0(3'd5, 2'b00);
    tick;
    chk("cnt_floor_then_set", sb, 24'h000010);
    chk("cnt_floor_full", {23'd0, full}, 24'h0);
`else
    chk("full_tied_low", {23'd0, full}, 24'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
